// File: rtl/card_dealer.sv
// Single-deck card source: draws an undealt slot starting at an LFSR-chosen index,
// probing forward until a free slot is found, then pulses the selected hand.
module card_dealer #(
  parameter int              NUM_HANDS = 2,
  parameter int              CARD_W    = 4,
  parameter logic [15:0]     SEED      = 16'hACE1,
  localparam int             HS_W      = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dealReq,
  input  logic [HS_W-1:0]      handSel,
  input  logic                 shuffle,
  output logic [NUM_HANDS-1:0] addNewCard,
  output logic [CARD_W-1:0]    newCardValue,
  output logic                 busy,
  output logic                 deckEmpty,
  output logic [5:0]           cardsRemaining
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic            lfsr_fb;
  logic [51:0]     used;
  logic [5:0]      idx;
  logic [HS_W-1:0] hsel;

  function automatic logic [5:0] start_idx(input logic [5:0] r);
    return (r >= 6'd52) ? (r - 6'd52) : r;
  endfunction

  function automatic logic [CARD_W-1:0] rank_of(input logic [5:0] i);
    logic [5:0] r;
    r = (i % 6'd13) + 6'd1;
    return CARD_W'(r);
  endfunction

  // Out-of-range selections map to no pulse; the card is still consumed.
  function automatic logic [NUM_HANDS-1:0] hand_onehot(input logic [HS_W-1:0] s);
    logic [NUM_HANDS-1:0] oh;
    oh = '0;
    for (int h = 0; h < NUM_HANDS; h++)
      if (32'(s) == h) oh[h] = 1'b1;
    return oh;
  endfunction

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign busy      = (state != IDLE);
  assign deckEmpty = (cardsRemaining == 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lfsr           <= SEED_NZ;
      used           <= '0;
      idx            <= '0;
      hsel           <= '0;
      cardsRemaining <= 6'd52;
      addNewCard     <= '0;
      newCardValue   <= '0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      addNewCard <= '0;
      case (state)
        IDLE: begin
          if (shuffle) begin
            used           <= '0;
            cardsRemaining <= 6'd52;
          end else if (dealReq && !deckEmpty) begin
            hsel  <= handSel;
            idx   <= start_idx(lfsr[5:0]);
            state <= CHECK;
          end
        end
        // Linear probe with wrap; a free slot is guaranteed since the deck was non-empty.
        CHECK: begin
          if (!used[idx]) state <= ISSUE;
          else            idx   <= (idx == 6'd51) ? 6'd0 : (idx + 6'd1);
        end
        ISSUE: begin
          addNewCard     <= hand_onehot(hsel);
          newCardValue   <= rank_of(idx);
          used[idx]      <= 1'b1;
          cardsRemaining <= cardsRemaining - 6'd1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
